// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared state encoding, control constants and widths for the vALU shift units
package alu_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 5;

  // Control encoding shared with the barrel shifter so one decoder drives both units
  localparam logic CTL0_LOGICAL = 1'b1;
  localparam logic CTL1_RIGHT   = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/iter_shifter_if.sv
// rtl/iter_shifter_if.sv - request/response handshake bundle between the ALU sequencer and iter_shifter
interface iter_shifter_if
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ctl0;
  logic             ctl1;
  logic [WIDTH-1:0] out;
  logic             done_valid;
  logic             done_ready;

  modport master (
    output start_valid, A, B, ctl0, ctl1, done_ready,
    input  start_ready, out, done_valid
  );

  modport slave (
    input  start_valid, A, B, ctl0, ctl1, done_ready,
    output start_ready, out, done_valid
  );

endinterface

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational one-position SLL/SRL/SRA step
module shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] in,
  input  logic             ctl0,
  input  logic             ctl1,
  output logic [WIDTH-1:0] out
);

  logic fill_bit;

  // Arithmetic left is the same as logical left, so ctl0 only matters for right shifts
  always_comb begin
    fill_bit = (ctl0 == CTL0_LOGICAL) ? 1'b0 : in[WIDTH-1];
    out      = {in[WIDTH-2:0], 1'b0};
    if (ctl1 == CTL1_RIGHT) begin
      out = {fill_bit, in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/iter_shifter.sv
// rtl/iter_shifter.sv - multi-cycle shifter moving one bit per clock behind valid/ready handshakes
module iter_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  iter_shifter_if.slave  bus
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ctl0_q, ctl0_d;
  logic               ctl1_q, ctl1_d;
  logic [WIDTH-1:0]   step_out;
  logic               start_ready;
  logic               done_valid;
  logic [CNT_W-1:0]   req_cnt;
  logic               unused_b_hi;

  assign req_cnt     = bus.B[CNT_W-1:0];
  assign unused_b_hi = ^bus.B[WIDTH-1:CNT_W];

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .in   (data_q),
    .ctl0 (ctl0_q),
    .ctl1 (ctl1_q),
    .out  (step_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      ctl0_q  <= 1'b0;
      ctl1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ctl0_q  <= ctl0_d;
      ctl1_q  <= ctl1_d;
    end
  end

  // start_ready is masked by rst so a request can never be seen as accepted during reset
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    ctl0_d      = ctl0_q;
    ctl1_d      = ctl1_q;
    start_ready = 1'b0;
    done_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready = !rst;
        if (bus.start_valid) begin
          data_d  = bus.A;
          cnt_d   = req_cnt;
          ctl0_d  = bus.ctl0;
          ctl1_d  = bus.ctl1;
          state_d = (req_cnt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d = step_out;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_valid = 1'b1;
        if (bus.done_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.start_ready = start_ready;
  assign bus.done_valid  = done_valid;
  assign bus.out         = data_q;

endmodule

// File: doc/iter_shifter.md
# iter_shifter

Multi-cycle shift unit for the vALU datapath. It performs SLL, SRL and SRA on a 32-bit operand and moves one bit position per clock. It replaces the 5-layer barrel shifter wherever area matters more than latency. A valid/ready request/response handshake sits on each side, so the ALU sequencer can issue an operation and collect the result when it is ready. Control encoding matches the barrel shifter's, so the ALU decoder drives either unit unchanged.

## Interface
Parameters:
- WIDTH, 32, operand and result width.
- CNT_W, 5, shift-count width. Only B[CNT_W-1:0] is used.

Ports:
- clk  in  1  clock. Single clock domain.
- rst  in  1  reset. Synchronous and active-high; sampled on the rising edge of clk.
- start_valid  in  1  request valid.
- start_ready  out  1  unit can accept a request.
- A  in  WIDTH  operand to shift.
- B  in  WIDTH  shift amount. Only B[4:0] is used.
- ctl0  in  1  1 selects a logical shift; 0 selects an arithmetic shift.
- ctl1  in  1  1 selects a right shift; 0 selects a left shift.
- out  out  WIDTH  result. Valid while done_valid is high.
- done_valid  out  1  result available.
- done_ready  in  1  consumer takes the result.

## Operation
- FSM states and transitions:
  - IDLE: start_ready=1, done_valid=0.
  - IDLE to SHIFT or DONE on accept (start_valid && start_ready at a rising edge).
  - SHIFT: start_ready=0, done_valid=0.
  - DONE: start_ready=0, done_valid=1.
- On accept:
  - Latch A into data_r, B[4:0] into cnt_r, and ctl0/ctl1 into mode registers.
  - Next state is DONE if B[4:0]==0; otherwise SHIFT.
  - A, B, ctl0 and ctl1 are ignored after the accept edge.
- SHIFT step (once per edge):
  - data_r is shifted by one position and cnt_r decrements.
  - When cnt_r==1 before the step, next state is DONE.
- Shift step rules:
  - Left (ctl1=0): data_r <= {data_r[30:0], 1'b0}, regardless of ctl0. Arithmetic left is identical to logical left.
  - Right logical (ctl1=1, ctl0=1): data_r <= {1'b0, data_r[31:1]}.
  - Right arithmetic (ctl1=1, ctl0=0): data_r <= {data_r[31], data_r[31:1]}. The sign bit is taken from the current data_r, which stays stable because it is replicated.
- DONE behaviour:
  - out = data_r, held constant until done_ready is sampled high.
  - On that edge the state returns to IDLE.
  - A new request is not accepted in the same edge; earliest accept is the following edge.
- Bits of B above [4] never affect the result. B=32 behaves as shift 0.
- out is driven from data_r in every state. It is defined only in DONE; the bench checks it only while done_valid=1.

## Timing
- Reset values:
  - State is IDLE.
  - data_r = 0, cnt_r = 0, out = 0, done_valid = 0.
  - start_ready = 0 during any cycle with rst=1, and 1 from the first cycle after rst deasserts.
- Latency is N+1 cycles from the accept edge to the first cycle with done_valid=1, where N = B[4:0]:
  - N=0 gives 1 cycle.
  - N=31 gives 32 cycles.
- Throughput is one operation per N+2 cycles when done_ready is held high: accept, N shift edges, one DONE-handshake edge.
- done_ready high outside DONE is ignored.
- start_valid outside IDLE is ignored and is not queued.
- Reset mid-operation (SHIFT or DONE): the operation is abandoned and all outputs return to reset values on that edge. No partial result is ever flagged valid.
- rst has priority over any handshake on the same edge.

## Structure
- Package alu_pkg holds:
  - state encoding: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10.
  - control constants: CTL0_LOGICAL=1, CTL1_RIGHT=1.
  - WIDTH and CNT_W defaults.
- Sub-module shift_step: combinational one-position shifter with ports (in[31:0], ctl0, ctl1, out[31:0]).
  - It is reused by the bench's reference model.
- Top level holds the FSM, cnt_r, data_r and the handshake logic.

## Test plan
- Reset then SLL: A=32'h0000_0001, B=4, ctl1=0 → out=32'h0000_0010; done_valid in cycle 5 after accept.
- SRA of a negative operand: A=32'h8000_0000, B=31, ctl0=0, ctl1=1 → out=32'hFFFF_FFFF after 32 cycles. The same operand with ctl0=1 gives out=32'h0000_0001.
- Zero count: A=32'hDEAD_BEEF, B=32'h0000_0020 (low bits 0) → out=32'hDEAD_BEEF; done_valid in cycle 1 after accept.
- Backpressure: done_ready held 0 for 10 cycles → out and done_valid stable and start_ready=0 throughout. Pulsing start_valid with new operands during the stall has no effect. After done_ready=1, start_ready=1 on the next cycle.
- Reset mid-SHIFT: A=32'hF0F0_F0F0, B=20, rst asserted on cycle 7 → out=0, done_valid=0, start_ready=1 after rst drops. The next request A=32'h1, B=1, left returns 32'h2.
- Randomised sweep: 1000 ops with random A, B, ctl0 and ctl1 versus a shift_step-iterated model. Checks per op: result equals the model, latency equals B[4:0]+1, and exactly one done handshake occurs.
